// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - op codes and flag helpers for the pipelined logic unit
package logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ANDN  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    // Callers zero-extend their WIDTH-bit value, which leaves the XOR-reduce unchanged.
    function automatic logic parity_f(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// rtl/logic_op_core.sv - combinational bitwise operation selector
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:   y = x & b;
            OP_OR:    y = x | b;
            OP_XOR:   y = x ^ b;
            OP_NOR:   y = ~(x | b);
            OP_NAND:  y = ~(x & b);
            OP_XNOR:  y = ~(x ^ b);
            OP_ANDN:  y = x & ~b;
            OP_PASSB: y = b;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage valid/ready bitwise logic unit with accumulator
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc_q
);

    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic             r_s1_acc_en;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_c;
    logic             r_zero;
    logic             r_parity;
    logic [WIDTH-1:0] r_acc;

    logic             w_s2_free;
    logic             w_accept;
    logic             w_advance;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;
    assign w_advance = r_s1_valid && w_s2_free;

    // Accumulator is read as the request leaves S1, so chained acc ops see the previous result.
    assign w_x = r_s1_acc_en ? r_acc : r_s1_a;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (r_s1_op),
        .x  (w_x),
        .b  (r_s1_b),
        .y  (w_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_op     <= '0;
            r_s1_acc_en <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_op     <= op;
                r_s1_acc_en <= acc_en;
                r_s1_a      <= a;
                r_s1_b      <= b;
            end
            r_s1_valid <= w_accept || (r_s1_valid && !w_advance);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_zero      <= 1'b1;
            r_parity    <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_c         <= w_y;
            r_zero      <= (w_y == '0);
            r_parity    <= parity_f(32'(w_y));
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Clear has priority over an accumulate write-back landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= ACC_INIT;
        end else if (acc_clr) begin
            r_acc <= ACC_INIT;
        end else if (w_advance && r_s1_acc_en) begin
            r_acc <= w_y;
        end
    end

    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign zero      = r_zero;
    assign parity    = r_parity;
    assign acc_q     = r_acc;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - directed self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, acc_en, acc_clr, out_valid, out_ready, zero, parity;
    logic [2:0] op;
    logic [3:0] a, b, c, acc_q;

    logic       in_valid_8, in_ready_8, acc_en_8, acc_clr_8, out_valid_8, out_ready_8, zero_8, parity_8;
    logic [2:0] op_8;
    logic [7:0] a_8, b_8, c_8, acc_q_8;

    int         n_checks = 0;
    int         n_errors = 0;
    int         idx;
    int         n_acc;
    logic       rdy;
    logic [3:0] got_q[$];
    logic [3:0] sweep_exp[8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0001,
                                 4'b0111, 4'b1001, 4'b0100, 4'b1010};

    logic_unit_pipe #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .acc_en(acc_en), .acc_clr(acc_clr), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .c(c), .zero(zero), .parity(parity), .acc_q(acc_q)
    );

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h5A)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
        .acc_en(acc_en_8), .acc_clr(acc_clr_8), .a(a_8), .b(b_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .c(c_8), .zero(zero_8), .parity(parity_8), .acc_q(acc_q_8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change only just after a rising edge, so the falling edge sees what the next edge will.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back(c);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; op = '0; acc_en = 0; acc_clr = 0; a = '0; b = '0; out_ready = 0;
        in_valid_8 = 0; op_8 = '0; acc_en_8 = 0; acc_clr_8 = 0; a_8 = '0; b_8 = '0; out_ready_8 = 1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_acc", 32'(acc_q), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_acc8_init", 32'(acc_q_8), 32'h5A);
        cyc();
        rst_n = 1'b1;

        // op sweep, back-to-back, result visible two steps after being presented
        out_ready = 1; a = 4'b1100; b = 4'b1010; acc_en = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 1) check("sweep_latency_not_early", 32'(out_valid), 32'd0);
            if (i >= 2) begin
                check($sformatf("sweep_valid_op%0d", i - 2), 32'(out_valid), 32'd1);
                check($sformatf("sweep_c_op%0d", i - 2), 32'(c), 32'(sweep_exp[i - 2]));
            end
            if (i < 8) begin
                in_valid = 1; op = 3'(i);
            end else begin
                in_valid = 0;
            end
        end
        repeat (2) cyc();

        // backpressure: ops 0..3 with consumer stalled for 5 cycles
        got_q.delete();
        out_ready = 0; in_valid = 1; idx = 0; op = 3'(idx); n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            #1 rdy = in_ready;
            cyc();
            if (rdy) begin
                n_acc++; idx++; op = 3'(idx);
            end
            if (i >= 2) check($sformatf("bp_c_stable%0d", i), 32'(c), 32'h8);
        end
        #1;
        check("bp_accepted", 32'(n_acc), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            #1 rdy = in_ready;
            cyc();
            if (rdy) begin
                idx++; op = 3'(idx);
            end
        end
        in_valid = 0;
        repeat (4) cyc();
        check("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) check($sformatf("bp_order%0d", i), 32'(got_q[i]), 32'(sweep_exp[i]));

        // accumulate chain; a is all ones so using a instead of acc would be visible
        got_q.delete();
        a = 4'b1111; acc_en = 1; in_valid = 1;
        op = OP_OR;  b = 4'b0001; cyc();
        op = OP_OR;  b = 4'b0100; cyc();
        op = OP_XOR; b = 4'b1111; cyc();
        in_valid = 0; acc_en = 0;
        repeat (3) cyc();
        check("acc_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("acc_c0", 32'(got_q[0]), 32'h1);
            check("acc_c1", 32'(got_q[1]), 32'h5);
            check("acc_c2", 32'(got_q[2]), 32'hA);
        end
        check("acc_final", 32'(acc_q), 32'hA);

        // asynchronous reset with both stages full
        out_ready = 0; in_valid = 1; op = OP_AND; a = 4'b1100; b = 4'b1010;
        cyc(); cyc();
        in_valid = 0;
        #1;
        check("arst_pre_full", 32'(out_valid), 32'd1);
        check("arst_pre_s1_full", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        check("arst_c", 32'(c), 32'd0);
        check("arst_acc", 32'(acc_q), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst_n = 1'b1; out_ready = 1;
        cyc();
        check("arst_no_output", 32'(out_valid), 32'd0);

        // acc_clr on the same edge as a write-back: acc 0 ^ 0110 -> c=0110, acc cleared
        in_valid = 1; op = OP_XOR; acc_en = 1; b = 4'b0110;
        cyc();
        in_valid = 0; acc_en = 0; acc_clr = 1;
        cyc();
        acc_clr = 0;
        check("clr_c", 32'(c), 32'h6);
        check("clr_valid", 32'(out_valid), 32'd1);
        check("clr_acc", 32'(acc_q), 32'd0);

        // flags at WIDTH=8
        in_valid_8 = 1; op_8 = OP_XOR; a_8 = 8'hFF; b_8 = 8'hFF;
        cyc();
        op_8 = OP_ANDN; a_8 = 8'h07; b_8 = 8'h00;
        cyc();
        in_valid_8 = 0;
        check("w8_xor_c", 32'(c_8), 32'h00);
        check("w8_xor_zero", 32'(zero_8), 32'd1);
        check("w8_xor_parity", 32'(parity_8), 32'd0);
        cyc();
        check("w8_andn_c", 32'(c_8), 32'h07);
        check("w8_andn_zero", 32'(zero_8), 32'd0);
        check("w8_andn_parity", 32'(parity_8), 32'd1);
        check("w8_acc_untouched", 32'(acc_q_8), 32'h5A);

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
